cpu_switch_sequencer: RTL and testbench
=======================================

# cpu_switch_sequencer

Sequences the shutdown and start-up of the four MultiComp cores (Z80-CP/M, 6502-Basic, 6809-Basic, 6809-Forth) when the OSD CPU selection changes or a user reset is requested. It sits in `emu` between `hps_io` status/buttons and the core instances. It owns the registered `cpu_sel` that drives all output muxes, plus per-core reset and clock-enable. Video is blanked while a switch is in progress.

## Interface
- `STABLE_CYCLES`, 1024: consecutive cycles a differing `cpu_req` must hold before acting.
- `QUIESCE_CYCLES`, 16: cycles the old core is held in reset with its clock still running.
- `HOLD_CYCLES`, 256: cycles all cores are held in reset with clocks gated.
- `RESET_CYCLES`, 4096: cycles the new core is clocked while still in reset.
- `MUTE_FRAMES`, 2: `vs` rising edges counted before unmuting.
- `MUTE_TIMEOUT`, 4194304: cycle cap on the MUTE state.
- `clk_sys  in  1`: system clock (CLK_50M domain).
- `reset  in  1`: asynchronous, active-high; drives all state to reset values.
- `cpu_req  in  2`: requested core (`status[8:7]`), synchronous to `clk_sys`.
- `user_reset  in  1`: level, synchronous (`status[0] | buttons[1]`).
- `vs  in  1`: vertical sync of the selected core, active-high, same clock domain.
- `cpu_sel  out  2`: active core index; reset 0.
- `core_reset_n  out  4`: per-core active-low reset; reset 4'b0000.
- `core_clk_en  out  4`: per-core clock enable; reset 4'b0000.
- `video_mute  out  1`: force black; reset 1.
- `busy  out  1`: high in any state except RUN; reset 1.

## Operation
- States: RUN, QUIESCE, HOLD, START, MUTE. State after reset release is HOLD, with `target` = `cpu_req` sampled on the first edge.
- Each timed state lasts exactly N cycles: its down-counter loads N-1 on entry and the state exits when the counter is 0. The counter is a single register sized by `$clog2` of the largest parameter.
- **RUN**
  - `core_reset_n` = one-hot(`cpu_sel`); `core_clk_en` = one-hot(`cpu_sel`); `video_mute` = 0.
  - Stability counter increments while `cpu_req != cpu_sel` and `cpu_req` equals its previous-cycle value. Otherwise it clears.
  - When the counter reaches `STABLE_CYCLES`: `target` <= `cpu_req`, go to QUIESCE.
  - `user_reset` = 1: `target` <= `cpu_sel`, go to QUIESCE. This takes priority over a pending request.
- **QUIESCE**: `core_reset_n` = 0, `core_clk_en` = one-hot(`cpu_sel`), `video_mute` = 1. Lasts `QUIESCE_CYCLES`, extended while `user_reset` = 1. Then go to HOLD.
- **HOLD**: all resets low, all clock enables 0, `video_mute` = 1. Lasts `HOLD_CYCLES`. On exit `cpu_sel` <= `target`, go to START.
- **START**: `core_clk_en` = one-hot(`cpu_sel`), `core_reset_n` = 0, `video_mute` = 1. Lasts `RESET_CYCLES`. Then go to MUTE.
- **MUTE**: `core_reset_n` = one-hot(`cpu_sel`), clock enabled, `video_mute` = 1. Exits to RUN on the `MUTE_FRAMES`-th `vs` rising edge, or after `MUTE_TIMEOUT` cycles, whichever comes first.
- **Simultaneous or mid-sequence events**
  - `user_reset` in START or MUTE restarts at QUIESCE with `target` = `cpu_sel`.
  - `cpu_req` changes during QUIESCE, HOLD, START or MUTE are ignored. They are re-evaluated in RUN, where the stability counter starts from 0.
  - Asynchronous `reset` at any point forces the reset values immediately. The sequence then restarts from HOLD.
- At most one bit of `core_clk_en` and of `core_reset_n` is ever set.

## Timing
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- Request latency: `core_reset_n[old]` falls on the edge where the stability counter hits `STABLE_CYCLES`. That is `STABLE_CYCLES` edges after the new `cpu_req` is first sampled.
- `cpu_sel` changes exactly `QUIESCE_CYCLES + HOLD_CYCLES` edges after QUIESCE entry. That edge is also the first cycle of START.
- `core_reset_n[new]` rises exactly `RESET_CYCLES` edges after `cpu_sel` changes.
- `vs` edge detection uses one register: an edge is counted when `vs` = 1 and `vs_d` = 0. A `vs` rising edge on the MUTE entry cycle counts.

## Configuration
- `SWITCH_MUTE_EN` defined: behaviour as above.
- `SWITCH_MUTE_EN` undefined:
  - MUTE state, frame counter and timeout are compiled out.
  - START exits directly to RUN, with `core_reset_n[new]` rising on the same edge.
  - `video_mute` is constant 0, including its reset value.

## Test plan
Parameters for all scenarios: STABLE=4, QUIESCE=2, HOLD=3, RESET=5, MUTE_FRAMES=2, MUTE_TIMEOUT=50.
- Reset release with `cpu_req`=2 -> `cpu_sel`=2 after 3 cycles. `core_clk_en`=4'b0100 for 5 cycles with `core_reset_n`=0, then `core_reset_n`=4'b0100. Two `vs` pulses -> `video_mute`=0, `busy`=0.
- In RUN with `cpu_sel`=0, `cpu_req`=3 held -> `core_reset_n` 4'b0001→0 after 4 cycles; `cpu_sel`=3 5 cycles later. Never two clock-enable bits set.
- `cpu_req` toggles 0→1→0 within 3 cycles -> no transition, `busy` stays 0.
- `user_reset` held 10 cycles in RUN (`cpu_sel`=1) -> QUIESCE lasts until release+2. `cpu_sel` stays 1, same core restarts.
- No `vs` in MUTE -> RUN after exactly 50 cycles.
- Async `reset` pulse mid-START -> outputs at reset values in the same cycle, sequence restarts from HOLD.

Source files
------------

// File: rtl/cpu_switch_sequencer.sv
// cpu_switch_sequencer
// Sequences the shutdown and start-up of the four MultiComp cores when the OSD
// CPU selection changes or a user reset is requested. Owns the registered
// cpu_sel that drives the output muxes, the per-core resets and clock enables,
// and blanks video while a switch is in progress.
//
// Build option SWITCH_MUTE_EN: when defined, video stays muted after start-up
// until MUTE_FRAMES vs rising edges are seen or MUTE_TIMEOUT cycles elapse.
// When undefined, the MUTE state is absent, START hands over directly to RUN
// and video_mute is tied low.
//
// Ports:
//   clk_sys       in   system clock
//   reset         in   asynchronous, active-high reset
//   cpu_req[1:0]  in   requested core
//   user_reset    in   level request to restart the current core
//   vs            in   vertical sync of the selected core
//   cpu_sel[1:0]  out  active core index
//   core_reset_n  out  per-core active-low reset (one-hot or zero)
//   core_clk_en   out  per-core clock enable (one-hot or zero)
//   video_mute    out  force black
//   busy          out  high whenever not in RUN
//
// state   | meaning
// RUN     | selected core running; watch for a stable new request
// QUIESCE | old core held in reset with its clock still running
// HOLD    | every core in reset with clocks gated; cpu_sel updates on exit
// START   | new core clocked but still in reset
// MUTE    | new core running, video kept black until frames settle

module cpu_switch_sequencer #(
    parameter int STABLE_CYCLES  = 1024,
    parameter int QUIESCE_CYCLES = 16,
    parameter int HOLD_CYCLES    = 256,
    parameter int RESET_CYCLES   = 4096,
    parameter int MUTE_FRAMES    = 2,
    parameter int MUTE_TIMEOUT   = 4194304
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] cpu_req,
    input  logic       user_reset,
    input  logic       vs,
    output logic [1:0] cpu_sel,
    output logic [3:0] core_reset_n,
    output logic [3:0] core_clk_en,
    output logic       video_mute,
    output logic       busy
);

`ifdef SWITCH_MUTE_EN
    localparam int MUTE_MAX = MUTE_TIMEOUT;
`else
    localparam int MUTE_MAX = 1;
`endif
    // One shared down-counter serves every timed state.
    localparam int T_M1  = (QUIESCE_CYCLES > HOLD_CYCLES) ? QUIESCE_CYCLES : HOLD_CYCLES;
    localparam int T_M2  = (T_M1 > RESET_CYCLES) ? T_M1 : RESET_CYCLES;
    localparam int T_MAX = (T_M2 > MUTE_MAX) ? T_M2 : MUTE_MAX;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int SW    = $clog2(STABLE_CYCLES + 1);

    localparam logic [TW-1:0] Q_LOAD     = TW'(QUIESCE_CYCLES - 1);
    localparam logic [TW-1:0] H_LOAD     = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] R_LOAD     = TW'(RESET_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LIM = SW'(STABLE_CYCLES);

    typedef enum logic [2:0] {
        RUN,
        QUIESCE,
        HOLD,
        START
`ifdef SWITCH_MUTE_EN
        , MUTE
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    target_q, target_d;
    logic [1:0]    sel_d;
    logic [SW-1:0] stable_q, stable_d, stable_inc;
    logic [1:0]    req_prev;
    logic          init_q;
    logic [3:0]    sel_oh;
    logic [3:0]    rst_n_d, clk_en_d;
    logic          busy_d;

`ifdef SWITCH_MUTE_EN
    localparam int            FW      = $clog2(MUTE_FRAMES + 1);
    localparam logic [TW-1:0] M_LOAD  = TW'(MUTE_TIMEOUT - 1);
    localparam logic [FW-1:0] FR_LAST = FW'(MUTE_FRAMES - 1);

    logic [FW-1:0] frames_q, frames_d;
    logic          vs_prev, vs_rise, mute_d;

    assign vs_rise = vs & ~vs_prev;
`else
    logic unused_mute_cfg;
    assign unused_mute_cfg = vs ^ (MUTE_FRAMES != 0) ^ (MUTE_TIMEOUT != 0);
`endif

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        // The very first edge after reset captures the initial request.
        target_d   = init_q ? cpu_req : target_q;
        sel_d      = cpu_sel;
        stable_d   = '0;
        stable_inc = stable_q + 1'b1;
`ifdef SWITCH_MUTE_EN
        frames_d   = frames_q;
`endif

        case (state_q)
            RUN: begin
                if (user_reset) begin
                    target_d = cpu_sel;
                    state_d  = QUIESCE;
                    timer_d  = Q_LOAD;
                end else if (cpu_req != cpu_sel && cpu_req == req_prev) begin
                    if (stable_inc == STABLE_LIM) begin
                        target_d = cpu_req;
                        state_d  = QUIESCE;
                        timer_d  = Q_LOAD;
                    end else begin
                        stable_d = stable_inc;
                    end
                end
            end
            QUIESCE: begin
                // Holding user_reset keeps re-arming the full quiesce period.
                if (user_reset) begin
                    timer_d = Q_LOAD;
                end else if (timer_q == '0) begin
                    state_d = HOLD;
                    timer_d = H_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            HOLD: begin
                if (timer_q == '0) begin
                    sel_d   = target_d;
                    state_d = START;
                    timer_d = R_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            START: begin
                if (user_reset) begin
                    target_d = cpu_sel;
                    state_d  = QUIESCE;
                    timer_d  = Q_LOAD;
                end else if (timer_q == '0) begin
`ifdef SWITCH_MUTE_EN
                    state_d  = MUTE;
                    timer_d  = M_LOAD;
                    frames_d = '0;
`else
                    state_d  = RUN;
`endif
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`ifdef SWITCH_MUTE_EN
            MUTE: begin
                if (user_reset) begin
                    target_d = cpu_sel;
                    state_d  = QUIESCE;
                    timer_d  = Q_LOAD;
                end else if ((vs_rise && frames_q == FR_LAST) || timer_q == '0) begin
                    state_d = RUN;
                end else begin
                    timer_d = timer_q - 1'b1;
                    if (vs_rise) begin
                        frames_d = frames_q + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = HOLD;
                timer_d = H_LOAD;
            end
        endcase

        // Outputs are decoded from the next state so they move with it.
        sel_oh   = 4'b0001 << sel_d;
        rst_n_d  = '0;
        clk_en_d = '0;
        busy_d   = (state_d != RUN);
`ifdef SWITCH_MUTE_EN
        mute_d   = (state_d != RUN);
`endif
        case (state_d)
            RUN: begin
                rst_n_d  = sel_oh;
                clk_en_d = sel_oh;
            end
            QUIESCE, START: begin
                clk_en_d = sel_oh;
            end
`ifdef SWITCH_MUTE_EN
            MUTE: begin
                rst_n_d  = sel_oh;
                clk_en_d = sel_oh;
            end
`endif
            default: begin
                rst_n_d  = '0;
                clk_en_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= HOLD;
            timer_q      <= H_LOAD;
            target_q     <= '0;
            cpu_sel      <= '0;
            stable_q     <= '0;
            req_prev     <= '0;
            init_q       <= 1'b1;
            core_reset_n <= '0;
            core_clk_en  <= '0;
            busy         <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            target_q     <= target_d;
            cpu_sel      <= sel_d;
            stable_q     <= stable_d;
            req_prev     <= cpu_req;
            init_q       <= 1'b0;
            core_reset_n <= rst_n_d;
            core_clk_en  <= clk_en_d;
            busy         <= busy_d;
        end
    end

`ifdef SWITCH_MUTE_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            frames_q   <= '0;
            vs_prev    <= 1'b0;
            video_mute <= 1'b1;
        end else begin
            frames_q   <= frames_d;
            vs_prev    <= vs;
            video_mute <= mute_d;
        end
    end
`else
    assign video_mute = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_switch_sequencer.sv
`timescale 1ns/1ps
module tb_cpu_switch_sequencer;

    localparam int STABLE = 4;
    localparam int QUI    = 2;
    localparam int HLD    = 3;
    localparam int RST    = 5;
    localparam int FRAMES = 2;
    localparam int TMO    = 50;
`ifdef SWITCH_MUTE_EN
    localparam bit MUTE_EN = 1'b1;
`else
    localparam bit MUTE_EN = 1'b0;
`endif

    localparam int PH_RUN   = 0;
    localparam int PH_QUI   = 1;
    localparam int PH_HOLD  = 2;
    localparam int PH_START = 3;
    localparam int PH_MUTE  = 4;

    logic       clk_sys    = 1'b0;
    logic       reset      = 1'b1;
    logic [1:0] cpu_req    = 2'd2;
    logic       user_reset = 1'b0;
    logic       vs         = 1'b0;
    logic [1:0] cpu_sel;
    logic [3:0] core_reset_n;
    logic [3:0] core_clk_en;
    logic       video_mute;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    cpu_switch_sequencer #(
        .STABLE_CYCLES (STABLE),
        .QUIESCE_CYCLES(QUI),
        .HOLD_CYCLES   (HLD),
        .RESET_CYCLES  (RST),
        .MUTE_FRAMES   (FRAMES),
        .MUTE_TIMEOUT  (TMO)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .user_reset  (user_reset),
        .vs          (vs),
        .cpu_sel     (cpu_sel),
        .core_reset_n(core_reset_n),
        .core_clk_en (core_clk_en),
        .video_mute  (video_mute),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phases are timed by absolute edge numbers, and request
    // stability by the edge at which the current request value first appeared.
    int         m_edge, m_ph, m_start, m_anchor, m_frames, m_since;
    logic [1:0] m_tgt, m_sel, m_req_prev;
    logic       m_vs_prev;
    logic [3:0] e_rst_n, e_clk_en;
    logic       e_mute, e_busy;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic m_enter(input int ph);
        m_ph    = ph;
        m_start = m_edge;
    endtask

    task automatic m_restart_same();
        m_tgt    = m_sel;
        m_enter(PH_QUI);
        m_anchor = m_edge;
    endtask

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_edge = 0; m_ph = PH_HOLD; m_start = 0; m_anchor = 0;
            m_frames = 0; m_since = 0;
            m_tgt = 2'd0; m_sel = 2'd0; m_req_prev = 2'd0; m_vs_prev = 1'b0;
        end else begin
            m_edge++;
            if (m_edge == 1) m_tgt = cpu_req;
            if (cpu_req != m_req_prev) m_since = m_edge;
            case (m_ph)
                PH_RUN: begin
                    if (user_reset) m_restart_same();
                    else if (cpu_req != m_sel && m_edge - max2(m_since, m_start) >= STABLE) begin
                        m_tgt    = cpu_req;
                        m_enter(PH_QUI);
                        m_anchor = m_edge;
                    end
                end
                PH_QUI: begin
                    if (user_reset) m_anchor = m_edge;
                    else if (m_edge - m_anchor >= QUI) m_enter(PH_HOLD);
                end
                PH_HOLD: begin
                    if (m_edge - m_start >= HLD) begin
                        m_sel = m_tgt;
                        m_enter(PH_START);
                    end
                end
                PH_START: begin
                    if (user_reset) m_restart_same();
                    else if (m_edge - m_start >= RST) begin
                        if (MUTE_EN) begin
                            m_enter(PH_MUTE);
                            m_frames = 0;
                        end else begin
                            m_enter(PH_RUN);
                        end
                    end
                end
                PH_MUTE: begin
                    if (user_reset) m_restart_same();
                    else begin
                        if (vs && !m_vs_prev) m_frames++;
                        if (m_frames >= FRAMES || m_edge - m_start >= TMO) m_enter(PH_RUN);
                    end
                end
                default: ;
            endcase
            m_req_prev = cpu_req;
            m_vs_prev  = vs;
        end
        e_rst_n  = 4'b0000;
        e_clk_en = 4'b0000;
        if (m_ph == PH_RUN || m_ph == PH_MUTE) e_rst_n = 4'b0001 << m_sel;
        if (m_ph != PH_HOLD) e_clk_en = 4'b0001 << m_sel;
        e_busy = (m_ph != PH_RUN);
        e_mute = MUTE_EN && (m_ph != PH_RUN);
    end

    always @(negedge clk_sys) begin
        check("cpu_sel", {30'd0, cpu_sel}, {30'd0, m_sel});
        check("core_reset_n", {28'd0, core_reset_n}, {28'd0, e_rst_n});
        check("core_clk_en", {28'd0, core_clk_en}, {28'd0, e_clk_en});
        check("video_mute", {31'd0, video_mute}, {31'd0, e_mute});
        check("busy", {31'd0, busy}, {31'd0, e_busy});
        check("clk_en_onehot", {31'd0, $countones(core_clk_en) <= 1}, 32'd1);
    end

    task automatic wait_busy(input logic level, input int budget, input string tag);
        int n = 0;
        while (busy !== level && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check(tag, {31'd0, busy}, {31'd0, level});
    endtask

    task automatic switch_to(input logic [1:0] req, input string tag);
        @(negedge clk_sys);
        cpu_req = req;
        wait_busy(1'b1, 20, {tag, "_start"});
        wait_busy(1'b0, 200, {tag, "_done"});
        check({tag, "_sel"}, {30'd0, cpu_sel}, {30'd0, req});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sel"}, {30'd0, cpu_sel}, 32'd0);
        check({tag, "_rst_n"}, {28'd0, core_reset_n}, 32'd0);
        check({tag, "_clk_en"}, {28'd0, core_clk_en}, 32'd0);
        check({tag, "_mute"}, {31'd0, video_mute}, {31'd0, MUTE_EN});
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    int n;
    int hold_left;
    int ur_left;

    initial begin
        // Reset release with cpu_req = 2
        repeat (3) @(negedge clk_sys);
        check_reset_vals("por");
        #2 reset = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1 check("rel_sel_e2", {30'd0, cpu_sel}, 32'd0);
        @(posedge clk_sys);
        #1 check("rel_sel_e3", {30'd0, cpu_sel}, 32'd2);
        check("rel_clk_en", {28'd0, core_clk_en}, 32'h4);
        check("rel_rst_n_start", {28'd0, core_reset_n}, 32'd0);
        repeat (4) @(posedge clk_sys);
        #1 check("rel_rst_n_e7", {28'd0, core_reset_n}, 32'd0);
        @(posedge clk_sys);
        #1 check("rel_rst_n_e8", {28'd0, core_reset_n}, 32'h4);
        repeat (2) begin
            @(negedge clk_sys) vs = 1'b1;
            @(negedge clk_sys) vs = 1'b0;
        end
        @(negedge clk_sys);
        check("rel_mute_off", {31'd0, video_mute}, 32'd0);
        check("rel_busy_off", {31'd0, busy}, 32'd0);

        // Request latency 0 -> 3
        switch_to(2'd0, "to0");
        @(negedge clk_sys) cpu_req = 2'd3;
        @(posedge clk_sys);
        n = 0;
        do begin
            @(posedge clk_sys); #1 n++;
        end while (core_reset_n !== 4'b0000 && n < 20);
        check("req_latency", n, 32'd4);
        n = 0;
        do begin
            @(posedge clk_sys); #1 n++;
        end while (cpu_sel !== 2'd3 && n < 20);
        check("sel_latency", n, 32'd5);
        wait_busy(1'b0, 200, "to3_done");

        // Short glitch on cpu_req must not start a switch
        @(negedge clk_sys) cpu_req = 2'd1;
        @(negedge clk_sys);
        @(negedge clk_sys) cpu_req = 2'd3;
        repeat (10) @(negedge clk_sys);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_sel", {30'd0, cpu_sel}, 32'd3);

        // Held user_reset restarts the same core
        switch_to(2'd1, "to1");
        @(negedge clk_sys) user_reset = 1'b1;
        repeat (10) @(negedge clk_sys);
        user_reset = 1'b0;
        n = 0;
        do begin
            @(posedge clk_sys); #1 n++;
        end while (core_clk_en !== 4'b0000 && n < 20);
        check("urst_release", n, 32'd2);
        wait_busy(1'b0, 200, "urst_done");
        check("urst_sel", {30'd0, cpu_sel}, 32'd1);

`ifdef SWITCH_MUTE_EN
        // No vs in MUTE: timeout ends it
        @(negedge clk_sys) user_reset = 1'b1;
        @(negedge clk_sys) user_reset = 1'b0;
        n = 0;
        do begin
            @(posedge clk_sys); #1 n++;
        end while (core_reset_n === 4'b0000 && n < 100);
        check("mute_entry", {28'd0, core_reset_n}, 32'h2);
        n = 0;
        do begin
            @(posedge clk_sys); #1 n++;
        end while (busy !== 1'b0 && n < 100);
        check("mute_timeout", n, TMO);
`endif

        // Async reset in the middle of START
        @(negedge clk_sys) cpu_req = 2'd2;
        n = 0;
        do begin
            @(posedge clk_sys); #1 n++;
        end while (cpu_sel !== 2'd2 && n < 50);
        check("mid_start_sel", {30'd0, cpu_sel}, 32'd2);
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        #2 reset = 1'b1;
        #1 check_reset_vals("async_rst");
        repeat (2) @(negedge clk_sys);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 check("restart_sel", {30'd0, cpu_sel}, 32'd2);
        check("restart_clk_en", {28'd0, core_clk_en}, 32'h4);
        wait_busy(1'b0, 200, "restart_done");

        // Randomized traffic against the model
        hold_left = 0;
        ur_left   = 0;
        repeat (2000) begin
            @(negedge clk_sys);
            if (hold_left == 0) begin
                cpu_req   = 2'($urandom_range(0, 3));
                hold_left = $urandom_range(1, 14);
            end else begin
                hold_left--;
            end
            if (ur_left > 0) begin
                user_reset = 1'b1;
                ur_left--;
            end else begin
                user_reset = 1'b0;
                if ($urandom_range(0, 149) == 0) ur_left = $urandom_range(1, 4);
            end
            vs = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk_sys);
        user_reset = 1'b0;
        vs         = 1'b0;
        repeat (3) @(negedge clk_sys);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
